// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU codes,
// write-back selects, FSM states and decoded instruction classes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_LDI   = 4'h9;
  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_JZ    = 4'hD;
  localparam logic [3:0] OP_MOV   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_MOV  = 4'hF;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_ALU   = 3'd1,
    C_LDI   = 3'd2,
    C_LOAD  = 3'd3,
    C_STORE = 3'd4,
    C_JMP   = 3'd5,
    C_JZ    = 3'd6,
    C_HALT  = 3'd7
  } cls_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and
// write-back source for the instruction held in the IR.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output cls_t       cls,
  output logic [3:0] alu_op,
  output logic [1:0] wb_sel
);

  always_comb begin
    cls    = C_NOP;
    alu_op = ALU_NONE;
    wb_sel = WB_ALU;
    case (opcode)
      OP_NOP:   cls = C_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        cls    = C_ALU;
        alu_op = opcode;
      end
      OP_MOV: begin
        cls    = C_ALU;
        alu_op = ALU_MOV;
      end
      OP_LDI: begin
        cls    = C_LDI;
        wb_sel = WB_IMM;
      end
      OP_LOAD: begin
        cls    = C_LOAD;
        wb_sel = WB_MEM;
      end
      OP_STORE: cls = C_STORE;
      OP_JMP:   cls = C_JMP;
      OP_JZ:    cls = C_JZ;
      default:  cls = C_HALT;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT
// sequencer that drives fetch, data-memory, register-file and PC controls.
module control_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fetch_req,
  input  logic              fetch_ack,
  input  logic [15:0]       instr,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [3:0]        alu_op,
  input  logic              alu_zero,
  output logic [3:0]        rd_sel,
  output logic [3:0]        rs_sel,
  output logic [7:0]        imm,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              zero_q,
  output logic              halted
);

  state_t     state, state_nxt;
  logic       run_q;
  logic [15:0] ir_q;
  cls_t       cls;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_wb_sel;
  logic       fetch_take;

  cu_decode u_decode (
    .opcode (ir_q[15:12]),
    .cls    (cls),
    .alu_op (dec_alu_op),
    .wb_sel (dec_wb_sel)
  );

  // run_q keeps every output quiet while reset is held and until the first
  // edge after release, so nothing is requested from the reset state itself.
  assign fetch_take = run_q && fetch_ack && (state == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      if (fetch_take)
        ir_q <= instr;
      if (state == S_EXECUTE && cls == C_ALU)
        zero_q <= alu_zero;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (fetch_take) state_nxt = S_DECODE;
      S_DECODE: begin
        if (cls == C_HALT)     state_nxt = S_HALT;
        else if (cls == C_NOP) state_nxt = S_FETCH;
        else                   state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (cls)
          C_ALU, C_LDI:     state_nxt = S_WRITEBACK;
          C_LOAD, C_STORE:  state_nxt = S_MEMORY;
          default:          state_nxt = S_FETCH;
        endcase
      end
      S_MEMORY:    if (mem_ack) state_nxt = (cls == C_LOAD) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    fetch_req = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_op    = ALU_NONE;
    halted    = 1'b0;
    if (run_q) begin
      case (state)
        S_FETCH: begin
          fetch_req = !fetch_ack;
          pc_inc    = fetch_ack;
        end
        S_EXECUTE: begin
          if (cls == C_ALU) alu_op = dec_alu_op;
          if (cls == C_JMP) pc_load = 1'b1;
          if (cls == C_JZ)  pc_load = zero_q;
        end
        S_MEMORY: begin
          mem_req = 1'b1;
          mem_we  = (cls == C_STORE);
        end
        S_WRITEBACK: begin
          reg_we = 1'b1;
          wb_sel = dec_wb_sel;
          if (cls == C_ALU) alu_op = dec_alu_op;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_sel    = ir_q[11:8];
  assign rs_sel    = ir_q[7:4];
  assign imm       = ir_q[7:0];
  assign pc_target = ir_q[ADDR_W-1:0];

endmodule
